// File: rtl/door_pkg.sv
// Shared definitions for the garage door plant, its controller and benches.
// State encodings are fixed 3-bit codes so the controller side can decode them.
package door_pkg;

    localparam logic [2:0] ST_STOP    = 3'd0;
    localparam logic [2:0] ST_SPIN_UP = 3'd1;
    localparam logic [2:0] ST_SPIN_DN = 3'd2;
    localparam logic [2:0] ST_RUN_UP  = 3'd3;
    localparam logic [2:0] ST_RUN_DN  = 3'd4;
    localparam logic [2:0] ST_FAULT   = 3'd5;

    typedef enum logic [2:0] {
        DS_STOP    = ST_STOP,
        DS_SPIN_UP = ST_SPIN_UP,
        DS_SPIN_DN = ST_SPIN_DN,
        DS_RUN_UP  = ST_RUN_UP,
        DS_RUN_DN  = ST_RUN_DN,
        DS_FAULT   = ST_FAULT
    } door_state_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/door_step_timer.sv
// Spin-up counter, step prescaler and overrun counter for the door plant.
// Each counter has a priority clear and an enable; terminal counts are combinational.
module door_step_timer
    import door_pkg::*;
#(
    parameter int SPINUP      = 2,
    parameter int STEP_DIV    = 4,
    parameter int OVERRUN_MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic spin_clr,
    input  logic spin_en,
    input  logic step_clr,
    input  logic step_en,
    input  logic ovr_clr,
    input  logic ovr_en,
    output logic spin_done,
    output logic step_tick,
    output logic overrun_hit
);

    localparam int SPIN_W = $clog2(SPINUP + 1);
    localparam int STEP_W = $clog2(STEP_DIV + 1);
    localparam int OVR_W  = $clog2(OVERRUN_MAX + 1);

    logic [SPIN_W-1:0] spin_cnt;
    logic [STEP_W-1:0] step_cnt;
    logic [OVR_W-1:0]  ovr_cnt;

    // Terminal counts fire on the cycle whose increment would reach the limit.
    assign spin_done   = spin_en && (spin_cnt == SPIN_W'(SPINUP - 1));
    assign step_tick   = step_en && (step_cnt == STEP_W'(STEP_DIV - 1));
    assign overrun_hit = ovr_en  && (ovr_cnt  == OVR_W'(OVERRUN_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst || spin_clr) begin
            spin_cnt <= '0;
        end else if (spin_en) begin
            spin_cnt <= spin_cnt + 1'b1;
        end

        if (rst || step_clr) begin
            step_cnt <= '0;
        end else if (step_en) begin
            step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
        end

        if (rst || ovr_clr) begin
            ovr_cnt <= '0;
        end else if (ovr_en) begin
            ovr_cnt <= ovr_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/garage_door_plant.sv
// Garage door mechanism model: motor commands in, limit switches and position out.
// Covers spin-up delay, finite travel rate, over-drive into a limit and dual drive.
module garage_door_plant
    import door_pkg::*;
#(
    parameter int TRAVEL_STEPS = 100,
    parameter int STEP_DIV     = 4,
    parameter int SPINUP       = 2,
    parameter int OVERRUN_MAX  = 8,
    parameter int POS_W        = $clog2(TRAVEL_STEPS + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             UP_M,
    input  logic             DN_M,
    output logic             UP_Max,
    output logic             DN_MAX,
    output logic [POS_W-1:0] Door_Pos,
    output logic             Moving,
    output logic             Fault,
    output logic [2:0]       dbg_state
);

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(TRAVEL_STEPS);

    door_state_e state;
    logic up_only, dn_only, dual;
    logic spin_en, step_en, ovr_en;
    logic spin_done, step_tick, overrun_hit;

    assign up_only = UP_M & ~DN_M;
    assign dn_only = DN_M & ~UP_M;
    assign dual    = UP_M & DN_M;

    assign spin_en = ((state == DS_SPIN_UP) && up_only) || ((state == DS_SPIN_DN) && dn_only);
    assign step_en = ((state == DS_RUN_UP)  && up_only) || ((state == DS_RUN_DN)  && dn_only);
    // Overrun only counts while pushing into the limit already reached.
    assign ovr_en  = ((state == DS_RUN_UP) && up_only && UP_Max) ||
                     ((state == DS_RUN_DN) && dn_only && DN_MAX);

    door_step_timer #(
        .SPINUP      (SPINUP),
        .STEP_DIV    (STEP_DIV),
        .OVERRUN_MAX (OVERRUN_MAX)
    ) u_timer (
        .clk         (CLK),
        .rst         (RST),
        .spin_clr    (~spin_en),
        .spin_en     (spin_en),
        .step_clr    (~step_en),
        .step_en     (step_en),
        .ovr_clr     (~step_en),
        .ovr_en      (ovr_en),
        .spin_done   (spin_done),
        .step_tick   (step_tick),
        .overrun_hit (overrun_hit)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= DS_STOP;
            Door_Pos <= '0;
        end else if (state != DS_FAULT && dual) begin
            state <= DS_FAULT;
        end else begin
            case (state)
                DS_STOP: begin
                    if (up_only)      state <= DS_SPIN_UP;
                    else if (dn_only) state <= DS_SPIN_DN;
                end
                DS_SPIN_UP: begin
                    if (!up_only)       state <= DS_STOP;
                    else if (spin_done) state <= DS_RUN_UP;
                end
                DS_SPIN_DN: begin
                    if (!dn_only)       state <= DS_STOP;
                    else if (spin_done) state <= DS_RUN_DN;
                end
                DS_RUN_UP: begin
                    if (!up_only)                   state    <= DS_STOP;
                    else if (overrun_hit)           state    <= DS_FAULT;
                    else if (step_tick && !UP_Max)  Door_Pos <= Door_Pos + 1'b1;
                end
                DS_RUN_DN: begin
                    if (!dn_only)                   state    <= DS_STOP;
                    else if (overrun_hit)           state    <= DS_FAULT;
                    else if (step_tick && !DN_MAX)  Door_Pos <= Door_Pos - 1'b1;
                end
                DS_FAULT: state <= DS_FAULT;
                default:  state <= DS_STOP;
            endcase
        end
    end

    assign UP_Max    = (Door_Pos == POS_MAX);
    assign DN_MAX    = (Door_Pos == '0);
    assign Moving    = (state == DS_RUN_UP) || (state == DS_RUN_DN);
    assign Fault     = (state == DS_FAULT);
    assign dbg_state = state;

endmodule
